// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision divide controller.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [30:0] INF_MAG = 31'h7F80_0000;

    localparam int unsigned N_PASS    = 5;
    localparam int unsigned PASS_BITS = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NORM,
        S_PACK,
        S_DONE
    } state_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   mant;
        logic             is_zero;
        logic             is_inf;
        logic             is_nan;
    } fp_cls_t;

endpackage

// File: rtl/fp_unpack_cls.sv
// Field extraction and special-value classification of one IEEE-754 single operand.
module fp_unpack_cls
    import fp_pkg::*;
(
    input  logic [31:0] f,
    output fp_cls_t     cls
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;

    always_comb begin
        exp_f       = f[EXP_W+MAN_W-1:MAN_W];
        man_f       = f[MAN_W-1:0];
        cls.sign    = f[31];
        cls.exp     = exp_f;
        cls.mant    = {1'b1, man_f};
        // Denormals flush to zero: any zero exponent field counts as zero.
        cls.is_zero = (exp_f == '0);
        cls.is_inf  = (exp_f == '1) && (man_f == '0);
        cls.is_nan  = (exp_f == '1) && (man_f != '0);
    end

endmodule

// File: rtl/fp_div_ctrl.sv
// Single-precision divide controller driving an external 32-bit integer divider.
// Define FP_DIV_ROUND_EN for round-to-nearest-even; otherwise the result is truncated.
module fp_div_ctrl
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] fa,
    input  logic [31:0] fb,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        flag_inv,
    output logic        flag_dz,
    output logic        flag_ovf,
    output logic        flag_unf,
    output logic        div_en,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic        div_done
);

    fp_cls_t cls_a, cls_b;

    fp_unpack_cls u_cls_a (.f(fa), .cls(cls_a));
    fp_unpack_cls u_cls_b (.f(fb), .cls(cls_b));

    state_e             state_q, state_d;
    logic [2:0]         pass_q, pass_d;
    logic               sign_q, sign_d;
    logic [EXP_W-1:0]   ea_q, ea_d, eb_q, eb_d;
    logic [MAN_W:0]     ma_q, ma_d, mb_q, mb_d;
    logic [28:0]        quo_q, quo_d;
    logic [31:0]        rem_q, rem_d;
    logic [MAN_W-1:0]   mant_q, mant_d;
    logic signed [9:0]  exp_q, exp_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [31:0]        result_q, result_d;
    logic               inv_q, inv_d, dz_q, dz_d, ovf_q, ovf_d, unf_q, unf_d;
    logic               div_en_q, div_en_d;
    logic [31:0]        div_a_q, div_a_d, div_b_q, div_b_d;

    logic               spec_hit, spec_inv, spec_dz;
    logic [31:0]        spec_res;
    logic               sign_ab;
    logic [MAN_W-1:0]   mant_r;
    logic signed [9:0]  exp_r;

`ifdef FP_DIV_ROUND_EN
    logic               guard_q, guard_d, sticky_q, sticky_d;
    logic               rnd_inc;
    logic [MAN_W:0]     mant_sum;
`endif

    always_comb begin
        sign_ab  = cls_a.sign ^ cls_b.sign;
        spec_hit = 1'b1;
        spec_inv = 1'b0;
        spec_dz  = 1'b0;
        spec_res = '0;
        if (cls_a.is_nan || cls_b.is_nan || (cls_a.is_zero && cls_b.is_zero) ||
            (cls_a.is_inf && cls_b.is_inf)) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else if (cls_a.is_inf) begin
            spec_res = {sign_ab, INF_MAG};
        end else if (cls_b.is_zero) begin
            spec_res = {sign_ab, INF_MAG};
            spec_dz  = 1'b1;
        end else if (cls_a.is_zero || cls_b.is_inf) begin
            spec_res = {sign_ab, 31'b0};
        end else begin
            spec_hit = 1'b0;
        end
    end

`ifdef FP_DIV_ROUND_EN
    always_comb begin
        rnd_inc  = guard_q & (sticky_q | mant_q[0]);
        mant_sum = {1'b0, mant_q} + {{MAN_W{1'b0}}, rnd_inc};
        mant_r   = mant_sum[MAN_W-1:0];
        exp_r    = mant_sum[MAN_W] ? exp_q + 10'sd1 : exp_q;
    end
`else
    always_comb begin
        mant_r = mant_q;
        exp_r  = exp_q;
    end
`endif

    always_comb begin
        state_d  = state_q;
        pass_d   = pass_q;
        sign_d   = sign_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        mant_d   = mant_q;
        exp_d    = exp_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        inv_d    = inv_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        div_en_d = 1'b0;
        div_a_d  = div_a_q;
        div_b_d  = div_b_q;
`ifdef FP_DIV_ROUND_EN
        guard_d  = guard_q;
        sticky_d = sticky_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_d   = sign_ab;
                    ea_d     = cls_a.exp;
                    eb_d     = cls_b.exp;
                    ma_d     = cls_a.mant;
                    mb_d     = cls_b.mant;
                    pass_d   = '0;
                    quo_d    = '0;
                    rem_d    = '0;
                    busy_d   = 1'b1;
                    result_d = '0;
                    inv_d    = 1'b0;
                    dz_d     = 1'b0;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    if (spec_hit) begin
                        result_d = spec_res;
                        inv_d    = spec_inv;
                        dz_d     = spec_dz;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                div_en_d = 1'b1;
                div_b_d  = {8'b0, mb_q};
                // Later passes feed the partial remainder back, 7 quotient bits at a time.
                div_a_d  = (pass_q == 3'd0) ? {8'b0, ma_q} : {rem_q[24:0], 7'b0};
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (div_done) begin
                    rem_d   = div_r;
                    quo_d   = (pass_q == 3'd0) ? {28'b0, div_q[0]}
                                               : {quo_q[21:0], div_q[PASS_BITS-1:0]};
                    pass_d  = pass_q + 3'd1;
                    state_d = (pass_q == 3'(N_PASS - 1)) ? S_NORM : S_ISSUE;
                end
            end
            S_NORM: begin
                if (quo_q[28]) begin
                    mant_d = quo_q[27:5];
                    exp_d  = $signed(10'(ea_q)) - $signed(10'(eb_q)) + 10'sd127;
                end else begin
                    mant_d = quo_q[26:4];
                    exp_d  = $signed(10'(ea_q)) - $signed(10'(eb_q)) + 10'sd126;
                end
`ifdef FP_DIV_ROUND_EN
                guard_d  = quo_q[28] ? quo_q[4] : quo_q[3];
                sticky_d = (|rem_q) | (quo_q[28] ? (|quo_q[3:0]) : (|quo_q[2:0]));
`endif
                state_d = S_PACK;
            end
            S_PACK: begin
                if (exp_r >= 10'sd255) begin
                    result_d = {sign_q, INF_MAG};
                    ovf_d    = 1'b1;
                end else if (exp_r <= 10'sd0) begin
                    result_d = {sign_q, 31'b0};
                    unf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_r[EXP_W-1:0], mant_r};
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            pass_q   <= '0;
            sign_q   <= 1'b0;
            ea_q     <= '0;
            eb_q     <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            mant_q   <= '0;
            exp_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            inv_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            div_en_q <= 1'b0;
            div_a_q  <= '0;
            div_b_q  <= '0;
`ifdef FP_DIV_ROUND_EN
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pass_q   <= pass_d;
            sign_q   <= sign_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            inv_q    <= inv_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            div_en_q <= div_en_d;
            div_a_q  <= div_a_d;
            div_b_q  <= div_b_d;
`ifdef FP_DIV_ROUND_EN
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
`endif
        end
    end

    logic unused_bits;
`ifdef FP_DIV_ROUND_EN
    assign unused_bits = ^{div_q[31:PASS_BITS], rem_q[31:25]};
`else
    assign unused_bits = ^{div_q[31:PASS_BITS], rem_q[31:25], quo_q[3:0]};
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign flag_inv = inv_q;
    assign flag_dz  = dz_q;
    assign flag_ovf = ovf_q;
    assign flag_unf = unf_q;
    assign div_en   = div_en_q;
    assign div_a    = div_a_q;
    assign div_b    = div_b_q;

endmodule

// File: tb/tb_fp_div_ctrl.sv
// Directed bench for fp_div_ctrl with a behavioural integer divider of configurable latency.
module tb_fp_div_ctrl;

    logic        clk, rst, start;
    logic [31:0] fa, fb;
    logic        busy, done;
    logic [31:0] result;
    logic        flag_inv, flag_dz, flag_ovf, flag_unf;
    logic        div_en;
    logic [31:0] div_a, div_b, div_q, div_r;
    logic        div_done;

    logic        model_done, stray_done;
    logic [31:0] model_q, model_r;
    int          n_chk, n_bad, lat;

    assign div_done = model_done | stray_done;
    assign div_q    = stray_done ? 32'hFFFF_FFFF : model_q;
    assign div_r    = stray_done ? 32'h0000_0001 : model_r;

`ifdef FP_DIV_ROUND_EN
    localparam logic [31:0] EXP_ONE_THIRD  = 32'h3EAA_AAAB;
    localparam logic [31:0] EXP_TWO_THIRDS = 32'h3F2A_AAAB;
`else
    localparam logic [31:0] EXP_ONE_THIRD  = 32'h3EAA_AAAA;
    localparam logic [31:0] EXP_TWO_THIRDS = 32'h3F2A_AAAA;
`endif

    fp_div_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .fa(fa), .fb(fb),
        .busy(busy), .done(done), .result(result),
        .flag_inv(flag_inv), .flag_dz(flag_dz), .flag_ovf(flag_ovf), .flag_unf(flag_unf),
        .div_en(div_en), .div_a(div_a), .div_b(div_b),
        .div_q(div_q), .div_r(div_r), .div_done(div_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Divider: operands seen with div_en, div_done presented lat cycles later.
    initial begin
        logic [31:0] oa, ob;
        model_done = 1'b0;
        model_q    = '0;
        model_r    = '0;
        forever begin
            @(negedge clk);
            if (div_en === 1'b1) begin
                oa = div_a;
                ob = div_b;
                for (int k = 1; k < lat; k++) @(negedge clk);
                if (rst === 1'b1) begin
                    chk("div_a_hold", div_a, oa);
                    chk("div_b_hold", div_b, ob);
                end
                model_q    = (ob != 0) ? oa / ob : 32'hFFFF_FFFF;
                model_r    = (ob != 0) ? oa % ob : 32'h0;
                model_done = 1'b1;
                @(negedge clk);
                model_done = 1'b0;
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit poke,
                          output logic [31:0] res, output logic [3:0] flg,
                          output int cyc, output int ens, output logic seen,
                          output logic busy_at_done);
        @(negedge clk);
        fa    = a;
        fb    = b;
        start = 1'b1;
        ens   = 0;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        if (div_en === 1'b1) ens++;
        while (done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (div_en === 1'b1) ens++;
            if (poke && cyc == 4) begin
                fa    = 32'h3F80_0000;
                fb    = 32'h0000_0000;
                start = 1'b1;
            end else if (poke && cyc == 5) begin
                start = 1'b0;
            end
        end
        seen         = done;
        res          = result;
        flg          = {flag_inv, flag_dz, flag_ovf, flag_unf};
        busy_at_done = busy;
    endtask

    task automatic do_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int l, input bit poke, input logic [31:0] er,
                           input logic [3:0] ef, input int elat, input int een);
        logic [31:0] res;
        logic [3:0]  flg;
        int          cyc, ens;
        logic        seen, bsy;
        lat = l;
        run_op(a, b, poke, res, flg, cyc, ens, seen, bsy);
        chk({tag, "_done"}, {31'b0, seen}, 32'd1);
        chk({tag, "_res"}, res, er);
        chk({tag, "_flags"}, {28'b0, flg}, {28'b0, ef});
        chk({tag, "_latency"}, cyc, elat);
        chk({tag, "_div_en"}, ens, een);
        chk({tag, "_busy"}, {31'b0, bsy}, 32'd1);
        @(negedge clk);
        chk({tag, "_after"}, {30'b0, busy, done}, 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {25'b0, busy, done, flag_inv, flag_dz, flag_ovf, flag_unf, div_en},
            32'd0);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_div_a"}, div_a, 32'd0);
        chk({tag, "_div_b"}, div_b, 32'd0);
    endtask

    initial begin
        int   seen_en;
        logic any;
        n_chk      = 0;
        n_bad      = 0;
        lat        = 1;
        rst        = 1'b0;
        start      = 1'b0;
        fa         = '0;
        fb         = '0;
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("rst_init");
        rst = 1'b1;
        @(negedge clk);

        // Normal path: latency 5*(1+Ld)+3
        do_case("six_by_two",  32'h40C0_0000, 32'h4000_0000, 1, 0, 32'h4040_0000, 4'b0000, 13, 5);
        do_case("one_third",   32'h3F80_0000, 32'h4040_0000, 3, 0, EXP_ONE_THIRD, 4'b0000, 23, 5);
        do_case("two_thirds",  32'h4000_0000, 32'h4040_0000, 2, 0, EXP_TWO_THIRDS, 4'b0000, 18, 5);
        do_case("neg_six",     32'hC0C0_0000, 32'h4000_0000, 1, 0, 32'hC040_0000, 4'b0000, 13, 5);
        do_case("one_by_one",  32'h3F80_0000, 32'h3F80_0000, 1, 0, 32'h3F80_0000, 4'b0000, 13, 5);
        do_case("overflow",    32'h7F7F_FFFF, 32'h0080_0000, 1, 0, 32'h7F80_0000, 4'b0010, 13, 5);
        do_case("underflow",   32'h0080_0000, 32'h4000_0000, 1, 0, 32'h0000_0000, 4'b0001, 13, 5);
        do_case("min_normal",  32'h0100_0000, 32'h4000_0000, 1, 0, 32'h0080_0000, 4'b0000, 13, 5);

        // Specials: done one cycle after start, no divider traffic
        do_case("div_zero",    32'h3F80_0000, 32'h0000_0000, 1, 0, 32'h7F80_0000, 4'b0100, 1, 0);
        do_case("zero_zero",   32'h0000_0000, 32'h0000_0000, 1, 0, 32'h7FC0_0000, 4'b1000, 1, 0);
        do_case("inf_inf",     32'h7F80_0000, 32'hFF80_0000, 1, 0, 32'h7FC0_0000, 4'b1000, 1, 0);
        do_case("nan_op",      32'h7FC0_0001, 32'h3F80_0000, 1, 0, 32'h7FC0_0000, 4'b1000, 1, 0);
        do_case("inf_fin",     32'h7F80_0000, 32'hC000_0000, 1, 0, 32'hFF80_0000, 4'b0000, 1, 0);
        do_case("fin_inf",     32'h4000_0000, 32'h7F80_0000, 1, 0, 32'h0000_0000, 4'b0000, 1, 0);
        do_case("neg_zero",    32'h8000_0000, 32'h4000_0000, 1, 0, 32'h8000_0000, 4'b0000, 1, 0);
        do_case("denorm",      32'h0000_0001, 32'hC000_0000, 1, 0, 32'h8000_0000, 4'b0000, 1, 0);

        // Start while busy must not disturb the operation in flight
        do_case("busy_start",  32'h40C0_0000, 32'h4000_0000, 2, 1, 32'h4040_0000, 4'b0000, 18, 5);

        // Divider completion while idle is ignored
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        any = busy | done;
        repeat (3) begin
            @(negedge clk);
            any = any | busy | done;
        end
        chk("stray_done_ignored", {31'b0, any}, 32'd0);

        // Reset during the WAIT of pass 2
        lat = 3;
        @(negedge clk);
        fa      = 32'h40C0_0000;
        fb      = 32'h4000_0000;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        seen_en = 0;
        for (int c = 0; c < 100 && seen_en < 3; c++) begin
            @(negedge clk);
            if (div_en === 1'b1) seen_en++;
        end
        chk("rst_reach_pass2", seen_en, 3);
        rst = 1'b0;
        #1;
        check_zero("rst_wait");
        repeat (5) @(negedge clk);
        check_zero("rst_hold");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        do_case("after_rst",   32'h40C0_0000, 32'h4000_0000, 1, 0, 32'h4040_0000, 4'b0000, 13, 5);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
